// File: rtl/id_stage.sv
// id_stage -- instruction-decode stage of a classic 5-stage MIPS-style pipeline.
//
// Holds the 32-entry register file and the main control decoder, and registers
// every decoded result into the ID/EX latch feeding the execute stage. A
// load-use hazard against the instruction currently in ID/EX raises 'stall'
// (fetch holds PC and IF/ID) and injects a bubble; a taken branch in MEM
// (EX_MEM_PCSrc) flushes the instruction being decoded.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   IF_ID_instr      instruction from the IF/ID latch
//   IF_ID_npc        PC+4 from the IF/ID latch
//   EX_MEM_PCSrc     taken branch in MEM; flush current decode
//   MEM_WB_RegWrite  write-back enable
//   MEM_WB_rd        write-back destination register
//   MEM_WB_wdata     write-back data
//   stall            combinational load-use hazard toward fetch
//   wb_ctlout        {RegWrite, MemtoReg}
//   m_ctlout         {Branch, MemRead, MemWrite}
//   ex_ctlout        {RegDst, ALUOp[1:0], ALUSrc}
//   npcout           registered PC+4
//   readdat1         registered rs value
//   readdat2         registered rt value
//   sign_ext         registered sign-extended immediate
//   instr_2016       registered rt field
//   instr_1511       registered rd field

module id_stage #(
    parameter int DWIDTH = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       IF_ID_instr,
    input  logic [DWIDTH-1:0] IF_ID_npc,
    input  logic              EX_MEM_PCSrc,
    input  logic              MEM_WB_RegWrite,
    input  logic [4:0]        MEM_WB_rd,
    input  logic [DWIDTH-1:0] MEM_WB_wdata,
    output logic              stall,
    output logic [1:0]        wb_ctlout,
    output logic [2:0]        m_ctlout,
    output logic [3:0]        ex_ctlout,
    output logic [DWIDTH-1:0] npcout,
    output logic [DWIDTH-1:0] readdat1,
    output logic [DWIDTH-1:0] readdat2,
    output logic [DWIDTH-1:0] sign_ext,
    output logic [4:0]        instr_2016,
    output logic [4:0]        instr_1511
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // Packed as {wb[1:0], m[2:0], ex[3:0]}; unknown opcodes decode to a NOP.
    function automatic logic [8:0] decode_ctl(input logic [5:0] op);
        logic [8:0] c;
        case (op)
            OP_RTYPE: c = {2'b10, 3'b000, 4'b1100};
            OP_LW:    c = {2'b11, 3'b010, 4'b0001};
            OP_SW:    c = {2'b00, 3'b001, 4'b0001};
            OP_BEQ:   c = {2'b00, 3'b100, 4'b0010};
            default:  c = 9'b0;
        endcase
        return c;
    endfunction

    function automatic logic signed [DWIDTH-1:0] sext16(input logic signed [15:0] v);
        return DWIDTH'(v);
    endfunction

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic signed [15:0] imm;

    assign opcode = IF_ID_instr[31:26];
    assign rs     = IF_ID_instr[25:21];
    assign rt     = IF_ID_instr[20:16];
    assign rd     = IF_ID_instr[15:11];
    assign imm    = IF_ID_instr[15:0];

    logic [DWIDTH-1:0] regs [NREGS];

    logic              wr_en;
    logic [DWIDTH-1:0] rd1_val;
    logic [DWIDTH-1:0] rd2_val;
    logic [8:0]        ctl_next;

    assign wr_en = MEM_WB_RegWrite && (MEM_WB_rd != 5'd0);

    // Write-back data is forwarded straight into the latch so that a value
    // retiring this cycle is visible to the instruction decoded this cycle.
    always_comb begin
        rd1_val = regs[rs];
        rd2_val = regs[rt];
        if (wr_en && (MEM_WB_rd == rs)) rd1_val = MEM_WB_wdata;
        if (wr_en && (MEM_WB_rd == rt)) rd2_val = MEM_WB_wdata;
        if (rs == 5'd0) rd1_val = '0;
        if (rt == 5'd0) rd2_val = '0;
    end

    // A load in ID/EX whose destination feeds this instruction must wait one
    // cycle; the bubble clears MemRead, so the stall releases by itself.
    assign stall = rst_n && m_ctlout[1] && (instr_2016 != 5'd0) &&
                   ((instr_2016 == rs) || (instr_2016 == rt));

    always_comb begin
        ctl_next = decode_ctl(opcode);
        if (EX_MEM_PCSrc || stall) ctl_next = 9'b0;
    end

    // ID/EX latch and register file
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_ctlout  <= '0;
            m_ctlout   <= '0;
            ex_ctlout  <= '0;
            npcout     <= '0;
            readdat1   <= '0;
            readdat2   <= '0;
            sign_ext   <= '0;
            instr_2016 <= '0;
            instr_1511 <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (wr_en) regs[MEM_WB_rd] <= MEM_WB_wdata;
            {wb_ctlout, m_ctlout, ex_ctlout} <= ctl_next;
            npcout     <= IF_ID_npc;
            readdat1   <= rd1_val;
            readdat2   <= rd2_val;
            sign_ext   <= sext16(imm);
            instr_2016 <= rt;
            instr_1511 <= rd;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_npc;
    logic        EX_MEM_PCSrc;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_rd;
    logic [31:0] MEM_WB_wdata;
    logic        stall;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [3:0]  ex_ctlout;
    logic [31:0] npcout;
    logic [31:0] readdat1;
    logic [31:0] readdat2;
    logic [31:0] sign_ext;
    logic [4:0]  instr_2016;
    logic [4:0]  instr_1511;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage #(.DWIDTH(32), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_instr(IF_ID_instr), .IF_ID_npc(IF_ID_npc),
        .EX_MEM_PCSrc(EX_MEM_PCSrc),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_rd(MEM_WB_rd),
        .MEM_WB_wdata(MEM_WB_wdata),
        .stall(stall), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout),
        .ex_ctlout(ex_ctlout), .npcout(npcout),
        .readdat1(readdat1), .readdat2(readdat2), .sign_ext(sign_ext),
        .instr_2016(instr_2016), .instr_1511(instr_1511)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic [8:0] exp);
        check(tag, {23'd0, wb_ctlout, m_ctlout, ex_ctlout}, {23'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0;
        IF_ID_instr = 32'h8C220004;
        IF_ID_npc = 32'h0000_0000;
        EX_MEM_PCSrc = 1'b0;
        MEM_WB_RegWrite = 1'b0;
        MEM_WB_rd = 5'd0;
        MEM_WB_wdata = 32'h0;

        // Reset with a load sitting in IF/ID
        step(); step();
        check("rst_ctl",   {23'd0, wb_ctlout, m_ctlout, ex_ctlout}, 32'h0);
        check("rst_npc",   npcout, 32'h0);
        check("rst_rd1",   readdat1, 32'h0);
        check("rst_sext",  sign_ext, 32'h0);
        check("rst_rt",    {27'd0, instr_2016}, 32'h0);
        check("rst_stall", {31'd0, stall}, 32'h0);

        // Read r1 right after reset
        rst_n = 1'b1;
        IF_ID_instr = 32'h00200000;
        step();
        check("r1_after_rst", readdat1, 32'h0);
        check_ctl("r1_ctl", 9'b10_000_1100);

        // Write r5, then read it back with add $3,$5,$0
        MEM_WB_RegWrite = 1'b1; MEM_WB_rd = 5'd5; MEM_WB_wdata = 32'h0000ABCD;
        IF_ID_instr = 32'h00000000;
        step();
        MEM_WB_RegWrite = 1'b0;
        IF_ID_instr = 32'h00A01820; IF_ID_npc = 32'h0000_0100;
        check("add_stall", {31'd0, stall}, 32'h0);
        step();
        check("add_rd1",  readdat1, 32'h0000ABCD);
        check("add_rd2",  readdat2, 32'h0);
        check_ctl("add_ctl", 9'b10_000_1100);
        check("add_rd",   {27'd0, instr_1511}, 32'd3);
        check("add_npc",  npcout, 32'h0000_0100);

        // Same-cycle bypass on both operands: sw $7,-4($7)
        MEM_WB_RegWrite = 1'b1; MEM_WB_rd = 5'd7; MEM_WB_wdata = 32'hDEADBEEF;
        IF_ID_instr = 32'hACE7FFFC;
        step();
        check("byp_rd1",  readdat1, 32'hDEADBEEF);
        check("byp_rd2",  readdat2, 32'hDEADBEEF);
        check("byp_sext", sign_ext, 32'hFFFFFFFC);
        check_ctl("sw_ctl", 9'b00_001_0001);

        // Write to r0 is dropped, including on the bypass path
        MEM_WB_rd = 5'd0; MEM_WB_wdata = 32'h00001234;
        IF_ID_instr = 32'h00000000;
        step();
        check("r0_byp", readdat1, 32'h0);
        MEM_WB_RegWrite = 1'b0;
        IF_ID_instr = 32'h00E00000;   // rs=r7 from the array, rt=r0
        step();
        check("r7_array", readdat1, 32'hDEADBEEF);
        check("r0_array", readdat2, 32'h0);

        // Load-use: lw $2,4($1) followed by add $4,$2,$3
        IF_ID_instr = 32'h8C220004;
        step();
        check_ctl("lw_ctl", 9'b11_010_0001);
        check("lw_sext", sign_ext, 32'h00000004);
        IF_ID_instr = 32'h00432020;
        #1;
        check("lu_stall", {31'd0, stall}, 32'h1);
        step();
        check_ctl("lu_bubble", 9'b0);
        check("lu_stall_drop", {31'd0, stall}, 32'h0);
        step();
        check_ctl("lu_add", 9'b10_000_1100);
        check("lu_add_rd", {27'd0, instr_1511}, 32'd4);

        // Flush a beq
        EX_MEM_PCSrc = 1'b1;
        IF_ID_instr = 32'h10220003; IF_ID_npc = 32'h0000_0200;
        step();
        EX_MEM_PCSrc = 1'b0;
        check_ctl("flush_ctl", 9'b0);
        check("flush_npc",  npcout, 32'h0000_0200);
        check("flush_sext", sign_ext, 32'h00000003);

        // beq decodes normally when not flushed
        step();
        check_ctl("beq_ctl", 9'b00_100_0010);

        // Unknown opcode
        IF_ID_instr = 32'hFC000000;
        step();
        check_ctl("nop_ctl", 9'b0);
        check("nop_stall", {31'd0, stall}, 32'h0);

        // lw $2,0($1) then lw $5,0($2): one stall
        IF_ID_instr = 32'h8C220000;
        step();
        IF_ID_instr = 32'h8C450000;
        #1;
        check("lwlw_stall", {31'd0, stall}, 32'h1);
        step();
        check_ctl("lwlw_bubble", 9'b0);
        check("lwlw_release", {31'd0, stall}, 32'h0);
        step();
        check_ctl("lwlw_second", 9'b11_010_0001);

        // lw $0,0($1) then add $6,$0,$0: rt=0 never stalls
        IF_ID_instr = 32'h8C200000;
        #1;
        check("lw_r0_nostall_a", {31'd0, stall}, 32'h0);
        step();
        IF_ID_instr = 32'h00003020;
        #1;
        check("lw_r0_nostall_b", {31'd0, stall}, 32'h0);
        step();
        check_ctl("lw_r0_add", 9'b10_000_1100);

        // Reset asserted mid-stall clears stall, controls and the register file
        IF_ID_instr = 32'h8CA20000;   // lw $2,0($5)
        step();
        IF_ID_instr = 32'h00A21820;   // add $3,$5,$2
        #1;
        check("mid_stall_pre", {31'd0, stall}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_stall_rst", {31'd0, stall}, 32'h0);
        step();
        check_ctl("mid_rst_ctl", 9'b0);
        rst_n = 1'b1;
        step();
        check_ctl("post_rst_add", 9'b10_000_1100);
        check("post_rst_r5", readdat1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
